// File: rtl/ivl_uvm_bus_responder.sv
// Responder end of the ivl_uvm request/response bus: small word memory, programmable wait states.
// Optional macro IVL_UVM_RSP_ADDR_CHK_EN flags out-of-range addresses instead of wrapping them.
module ivl_uvm_bus_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [15:0]       txn_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [15:0]         txn_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                cap_s;
  logic                commit_s;
  logic                txn_inc_s;
  logic                c_wr_s;
  logic [ADDR_W-1:0]   c_addr_s;
  logic [DATA_W-1:0]   c_wdata_s;
  logic [IDX_W-1:0]    idx_s;
  logic                in_range_s;

  // Next state; c_* select the access committed on the edge entering RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_s     = 1'b0;
    commit_s  = 1'b0;
    txn_inc_s = 1'b0;
    c_wr_s    = wr_q;
    c_addr_s  = addr_q;
    c_wdata_s = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cap_s     = 1'b1;
          c_wr_s    = req_wr;
          c_addr_s  = req_addr;
          c_wdata_s = req_wdata;
          if (wait_cfg == {WAIT_W{1'b0}}) begin
            state_d  = S_RESP;
            commit_s = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = wait_cfg;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_W'(1)) begin
          state_d  = S_RESP;
          commit_s = 1'b1;
          cnt_d    = {WAIT_W{1'b0}};
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d   = S_IDLE;
          txn_inc_s = 1'b1;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign idx_s = c_addr_s[IDX_W-1:0];

`ifdef IVL_UVM_RSP_ADDR_CHK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  assign in_range_s = ({1'b0, c_addr_s} < DEPTH_L);
`else
  // Upper address bits are deliberately ignored: the index wraps modulo DEPTH.
  logic unused_addr_s;
  assign unused_addr_s = ^c_addr_s;
  assign in_range_s    = 1'b1;
`endif

  // State, captured request, memory and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {WAIT_W{1'b0}};
      wr_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
      err_q   <= 1'b0;
      txn_q   <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap_s) begin
        wr_q    <= req_wr;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit_s) begin
        err_q <= ~in_range_s;
        if (c_wr_s) begin
          rdata_q <= {DATA_W{1'b0}};
          if (in_range_s) begin
            mem_q[idx_s] <= c_wdata_s;
          end
        end else begin
          rdata_q <= in_range_s ? mem_q[idx_s] : {DATA_W{1'b0}};
        end
      end
      if (txn_inc_s) begin
        txn_q <= txn_q + 16'd1;
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_ivl_uvm_bus_responder.sv
// Bench for ivl_uvm_bus_responder: directed vector table, hand-written corner sequences,
// then random transactions checked against an array-based memory model.
module tb_ivl_uvm_bus_responder;

`ifdef IVL_UVM_RSP_ADDR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [7:0]  req_addr = 8'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  wait_cfg = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [15:0] txn_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [DEPTH];
  int          model_txn;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          wt;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  ivl_uvm_bus_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .wait_cfg  (wait_cfg),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour of one transaction: wraps or flags out-of-range addresses.
  task automatic model_txn_apply(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err);
    int idx;
    idx = int'(addr) % DEPTH;
    rdata = 32'd0;
    err = 1'b0;
    if (CHK && int'(addr) >= DEPTH) begin
      err = 1'b1;
    end else if (wr) begin
      model_mem[idx] = wdata;
    end else begin
      rdata = model_mem[idx];
    end
    model_txn = (model_txn + 1) % 65536;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    model_txn = 0;
  endtask

  // Entered and left at #1 after a rising edge with the DUT idle.
  task automatic run_txn(input string tag, input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                         input int wt, input int hold, input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    wait_cfg  = 4'(wt);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = 32'h0BAD_0BAD;
    wait_cfg  = 4'd0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      check({tag, " busy_wait"}, busy, 1'b1);
      @(posedge clk); #1;
      lat++;
    end
    if (rsp_valid !== 1'b1) begin
      check({tag, " rsp_timeout"}, rsp_valid, 1'b1);
      return;
    end
    check({tag, " latency"}, lat, 1 + wt);
    check({tag, " rdata"}, rsp_rdata, exp_rdata);
    check({tag, " err"}, rsp_err, exp_err);
    check({tag, " busy_resp"}, busy, 1'b1);
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 8'd0;
      req_wdata = 32'hFFFF_0000;
      @(posedge clk); #1;
      check({tag, " hold_valid"}, rsp_valid, 1'b1);
      check({tag, " hold_rdata"}, rsp_rdata, exp_rdata);
      check({tag, " hold_err"}, rsp_err, exp_err);
      check({tag, " hold_req_ready"}, req_ready, 1'b0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " post_valid"}, rsp_valid, 1'b0);
    check({tag, " post_req_ready"}, req_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] m_rdata;
    logic        m_err;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          wt;
    int          seen;

    vecs[0]  = '{1'b0, 8'd5,  32'h0,         0,  0, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 8'd3,  32'hDEADBEEF,  0,  0, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 8'd3,  32'h0,         0,  0, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b0, 8'd3,  32'h0,         5,  0, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b1, 8'd3,  32'h00000055,  2,  4, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 8'd20, 32'h00001234,  1,  0, 32'h0, CHK};
    vecs[6]  = '{1'b0, 8'd4,  32'h0,         0,  0, CHK ? 32'h0 : 32'h1234, 1'b0};
    vecs[7]  = '{1'b0, 8'd20, 32'h0,         3,  0, CHK ? 32'h0 : 32'h1234, CHK};
    vecs[8]  = '{1'b0, 8'd3,  32'h0,         0,  1, 32'h00000055, 1'b0};
    vecs[9]  = '{1'b1, 8'd15, 32'hA5A5A5A5, 15,  2, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 8'd15, 32'h0,         0,  0, 32'hA5A5A5A5, 1'b0};
    vecs[11] = '{1'b0, 8'd0,  32'h0,         1,  0, 32'h0, 1'b0};

    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset req_ready", req_ready, 1'b1);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset txn_count", txn_count, 16'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", rsp_err, 1'b0);

    // rsp_ready while idle must not count as a handshake.
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("idle rsp_ready txn_count", txn_count, 16'd0);
    check("idle rsp_ready rsp_valid", rsp_valid, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].wt, vecs[i].hold, vecs[i].exp_rdata, vecs[i].exp_err);
      model_txn_apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata, m_rdata, m_err);
      check($sformatf("vec%0d txn_count", i), txn_count, 16'(i + 1));
    end

    for (int n = 0; n < 60; n++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = 8'($urandom_range(0, 31));
      wdata = $urandom;
      wt    = int'($urandom_range(0, 3));
      model_txn_apply(wr, addr, wdata, m_rdata, m_err);
      run_txn($sformatf("rnd%0d", n), wr, addr, wdata, wt, int'($urandom_range(0, 2)), m_rdata, m_err);
      check($sformatf("rnd%0d txn_count", n), txn_count, 16'(model_txn));
    end

    // Reset in the middle of a write's WAIT phase abandons it.
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 8'd7;
    req_wdata = 32'h0000_0077;
    wait_cfg  = 4'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst busy_before", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("midrst rsp_valid", rsp_valid, 1'b0);
    check("midrst busy", busy, 1'b0);
    check("midrst req_ready", req_ready, 1'b1);
    check("midrst txn_count", txn_count, 16'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen++;
    end
    check("midrst no_response", seen, 0);
    run_txn("midrst read7", 1'b0, 8'd7, 32'h0, 0, 0, 32'h0, 1'b0);
    check("midrst txn_count_after", txn_count, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
